// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: glyph table, bit order and decoder FSM states.
// The display driver imports the same constants so encoder and decoder stay in step.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD,
        ST_ERR
    } seg_state_t;

    // Active-high a..g patterns for hex 0..F, indexed by value.
    localparam logic [6:0] SEG_GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int SEG_A_BIT  = 0;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    // Digit strobes are active-low; bit 0 is the rightmost digit.
    localparam logic DIG_ACTIVE    = 1'b0;
    localparam int   DIG_RIGHTMOST = 0;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational a..g pattern to hex value; ok=0 (value 0) for anything that is not a glyph.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       ok,
    output logic [3:0] value
);

    always_comb begin
        ok    = 1'b0;
        value = 4'h0;
        if (pattern != SEG_BLANK) begin
            for (int i = 0; i < 16; i++) begin
                if (pattern == SEG_GLYPHS[i]) begin
                    ok    = 1'b1;
                    value = 4'(i);
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a scanned 7-segment bus and publishes coherent 8-digit frames.
// Each digit is captured only after dig and seg have been stable for SETTLE cycles.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 4096,
    parameter int NDIG    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        seg,
    input  logic [NDIG-1:0]   dig,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   digit_ok,
    output logic [NDIG-1:0]   dp,
    output logic              frame_stb,
    output logic              stale,
    output logic [7:0]        err_cnt,
    output seg_state_t        state
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [NDIG-1:0]   dig_m, dig_s, dig_p, dig_act;
    logic [7:0]        seg_m, seg_s, seg_p;
    logic              dig_onehot, dig_idle, dig_changed, seg_changed;
    logic [IW-1:0]     dig_idx;
    logic              dec_ok;
    logic [3:0]        dec_val;
    logic              capture;
    logic [CW-1:0]     settle_cnt;
    logic [TW-1:0]     to_cnt;
    logic [4*NDIG-1:0] sh_val, sh_val_nx;
    logic [NDIG-1:0]   sh_ok, sh_ok_nx, sh_dp, sh_dp_nx, mask, mask_nx;

    seg_glyph_decode u_decode (
        .pattern (seg_s[SEG_G_BIT:SEG_A_BIT]),
        .ok      (dec_ok),
        .value   (dec_val)
    );

    assign dig_act     = DIG_ACTIVE ? dig_s : ~dig_s;
    assign dig_onehot  = $onehot(dig_act);
    assign dig_idle    = (dig_act == '0);
    assign dig_changed = (dig_s != dig_p);
    assign seg_changed = (seg_s != seg_p);
    assign capture     = (state == ST_SETTLE) && !dig_changed && !seg_changed &&
                         (settle_cnt == CW'(SETTLE - 2));

    always_comb begin
        dig_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_act[i]) dig_idx = IW'(i);
        end
    end

    // Shadow including this cycle's capture, so a same-cycle commit sees it.
    always_comb begin
        sh_val_nx = sh_val;
        sh_ok_nx  = sh_ok;
        sh_dp_nx  = sh_dp;
        mask_nx   = mask;
        if (capture) begin
            sh_val_nx[4*dig_idx +: 4] = dec_val;
            sh_ok_nx[dig_idx]         = dec_ok;
            sh_dp_nx[dig_idx]         = seg_s[SEG_DP_BIT];
            mask_nx[dig_idx]          = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dig_m      <= '1;
            dig_s      <= '1;
            dig_p      <= '1;
            seg_m      <= '0;
            seg_s      <= '0;
            seg_p      <= '0;
            state      <= ST_IDLE;
            settle_cnt <= '0;
            to_cnt     <= '0;
            sh_val     <= '0;
            sh_ok      <= '0;
            sh_dp      <= '0;
            mask       <= '0;
            digits     <= '0;
            digit_ok   <= '0;
            dp         <= '0;
            frame_stb  <= 1'b0;
            stale      <= 1'b0;
            err_cnt    <= '0;
        end else begin
            dig_m <= dig;
            dig_s <= dig_m;
            dig_p <= dig_s;
            seg_m <= seg;
            seg_s <= seg_m;
            seg_p <= seg_s;

            case (state)
                ST_IDLE: begin
                    settle_cnt <= '0;
                    // An illegal code counts once per appearance, not per cycle held.
                    if (dig_onehot) state <= ST_SETTLE;
                    else if (!dig_idle && dig_changed) state <= ST_ERR;
                end
                ST_SETTLE: begin
                    if (dig_changed || seg_changed) begin
                        settle_cnt <= '0;
                        if (dig_idle) state <= ST_IDLE;
                        else if (!dig_onehot) state <= ST_ERR;
                    end else if (capture) begin
                        state <= ST_HOLD;
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    settle_cnt <= '0;
                    if (dig_changed) begin
                        if (dig_onehot) state <= ST_SETTLE;
                        else if (dig_idle) state <= ST_IDLE;
                        else state <= ST_ERR;
                    end
                end
                default: begin
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    state <= ST_IDLE;
                end
            endcase

            sh_val <= sh_val_nx;
            sh_ok  <= sh_ok_nx;
            sh_dp  <= sh_dp_nx;
            if (&mask) begin
                digits    <= sh_val_nx;
                digit_ok  <= sh_ok_nx;
                dp        <= sh_dp_nx;
                frame_stb <= 1'b1;
                mask      <= '0;
            end else begin
                frame_stb <= 1'b0;
                mask      <= mask_nx;
            end

            if (capture) begin
                to_cnt <= '0;
                stale  <= 1'b0;
            end else if (to_cnt != TW'(TIMEOUT)) begin
                to_cnt <= to_cnt + TW'(1);
                if (to_cnt == TW'(TIMEOUT - 1)) stale <= 1'b1;
            end
        end
    end

endmodule
